// File: rtl/next_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_unit
//  Description : Program counter, carry flag and run/halt control. Resolves
//                conditional/unconditional branches for the instruction at
//                the current PC and produces the next PC and link value.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_unit #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         OFF_W    = 26,
  parameter logic [DATA_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              unconditional,
  input  logic [2:0]        conditional,
  input  logic              AdSel,
  input  logic              halt,
  input  logic [DATA_W-1:0] rs_value,
  input  logic [OFF_W-1:0]  offset,
  input  logic              carry_we,
  input  logic              carry_in,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              branch_taken,
  output logic              carry_flag,
  output logic              running,
  output logic              halted
);

  // Branch condition codes from the decoder
  localparam logic [2:0] C_COND_NONE = 3'b000;
  localparam logic [2:0] C_COND_BLTZ = 3'b001;
  localparam logic [2:0] C_COND_BZ   = 3'b010;
  localparam logic [2:0] C_COND_BNZ  = 3'b011;
  localparam logic [2:0] C_COND_BCY  = 3'b100;
  localparam logic [2:0] C_COND_BNCY = 3'b101;

  // Offset is a word offset; sign bits fill what the shifted field leaves
  localparam int unsigned C_EXT_W = DATA_W - OFF_W - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              carry_q;

  logic              w_cond_hit;
  logic              w_taken;
  logic [DATA_W-1:0] w_pc_plus4;
  logic [DATA_W-1:0] w_off_bytes;
  logic [DATA_W-1:0] w_target;

  assign w_pc_plus4  = pc_q + DATA_W'(4);
  assign w_off_bytes = {{C_EXT_W{offset[OFF_W-1]}}, offset, 2'b00};

  // Evaluate the selected condition against registered flag and rs data
  always_comb begin
    w_cond_hit = 1'b0;
    case (conditional)
      C_COND_NONE: w_cond_hit = 1'b0;
      C_COND_BLTZ: w_cond_hit = rs_value[DATA_W-1];
      C_COND_BZ:   w_cond_hit = (rs_value == '0);
      C_COND_BNZ:  w_cond_hit = (rs_value != '0);
      C_COND_BCY:  w_cond_hit = carry_q;
      C_COND_BNCY: w_cond_hit = ~carry_q;
      default:     w_cond_hit = 1'b0;
    endcase
  end

  // Redirects only exist for a live, non-halt instruction
  assign w_taken  = (state_q == S_RUN) && !halt && (unconditional || w_cond_hit);

  // Register-indirect targets are silently word aligned
  assign w_target = AdSel ? {rs_value[DATA_W-1:2], 2'b00}
                          : w_pc_plus4 + w_off_bytes;

  // Next sequential or redirected PC for a RUN cycle that advances
  always_comb begin
    pc_d = w_taken ? w_target : w_pc_plus4;
  end

  // State, PC and carry update; reset overrides everything including stall
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!stall) begin
            if (halt) begin
              state_q <= S_HALTED;
            end else begin
              pc_q <= pc_d;
            end
            if (carry_we) carry_q <= carry_in;
          end
        end
        S_HALTED: begin
          state_q <= S_HALTED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc           = pc_q;
  assign pc_plus4     = w_pc_plus4;
  assign branch_taken = w_taken;
  assign carry_flag   = carry_q;
  assign running      = (state_q == S_RUN);
  assign halted       = (state_q == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_next_pc_unit
//  Description : Self-checking bench for next_pc_unit with a behavioural
//                reference model, directed steps and randomized cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_next_pc_unit;

  localparam int DATA_W = 32;
  localparam int OFF_W  = 26;

  logic              clk = 1'b0;
  logic              reset, start, stall, unconditional, AdSel, halt;
  logic [2:0]        conditional;
  logic [DATA_W-1:0] rs_value;
  logic [OFF_W-1:0]  offset;
  logic              carry_we, carry_in;
  logic [DATA_W-1:0] pc, pc_plus4;
  logic              branch_taken, carry_flag, running, halted;

  next_pc_unit #(.DATA_W(DATA_W), .OFF_W(OFF_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .unconditional(unconditional), .conditional(conditional), .AdSel(AdSel),
    .halt(halt), .rs_value(rs_value), .offset(offset), .carry_we(carry_we),
    .carry_in(carry_in), .pc(pc), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .carry_flag(carry_flag),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 run, 2 halted
  int        m_mode  = 0;
  bit [31:0] m_pc    = 0;
  bit        m_carry = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_taken();
    bit c;
    case (conditional)
      3'd1:    c = ($signed(rs_value) < 0);
      3'd2:    c = (rs_value == 0);
      3'd3:    c = (rs_value != 0);
      3'd4:    c = m_carry;
      3'd5:    c = !m_carry;
      default: c = 0;
    endcase
    return (m_mode == 1) && !halt && (unconditional || c);
  endfunction

  function automatic bit [31:0] model_target();
    longint so;
    so = longint'(offset);
    if (offset[OFF_W-1]) so = so - (longint'(1) << OFF_W);
    if (AdSel) return (rs_value / 4) * 4;
    return 32'(longint'(m_pc) + 4 + so * 4);
  endfunction

  // One clock: check combinational outputs, advance model, check registers
  task automatic cycle();
    bit        tk;
    bit [31:0] tgt;
    #1;
    tk  = model_taken();
    tgt = model_target();
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, tk});
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    if (reset) begin
      m_mode = 0; m_pc = 0; m_carry = 0;
    end else if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1 && !stall) begin
      if (halt) m_mode = 2;
      else m_pc = tk ? tgt : m_pc + 32'd4;
      if (carry_we) m_carry = carry_in;
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("carry_flag", {31'b0, carry_flag}, {31'b0, m_carry});
    chk("running", {31'b0, running}, {31'b0, m_mode == 1});
    chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
  endtask

  task automatic nop();
    reset = 0; start = 0; stall = 0; unconditional = 0; conditional = 0;
    AdSel = 0; halt = 0; rs_value = 0; offset = 0; carry_we = 0; carry_in = 0;
  endtask

  initial begin
    nop();
    // Reset, then start and run sequentially
    reset = 1; cycle(); cycle();
    chk("reset_pc", pc, 32'h0);
    nop(); start = 1; cycle();
    start = 0; repeat (4) cycle();
    chk("seq_pc16", pc, 32'h10);
    // bz taken backwards, then not taken
    conditional = 3'd2; rs_value = 0; offset = -26'sd2; cycle();
    chk("bz_taken", pc, 32'h0C);
    nop(); cycle();
    conditional = 3'd2; rs_value = 5; offset = -26'sd2; cycle();
    chk("bz_not_taken", pc, 32'h14);
    // jump to 0x20, set carry, then bcy
    nop(); unconditional = 1; offset = 26'd2; cycle();
    chk("b_to_20", pc, 32'h20);
    nop(); carry_we = 1; carry_in = 1; cycle();
    nop(); conditional = 3'd4; offset = 26'd3; cycle();
    chk("bcy_taken", pc, 32'h34);
    nop(); conditional = 3'd5; offset = 26'd3; cycle();
    chk("bncy_not_taken", pc, 32'h38);
    nop(); carry_we = 1; carry_in = 0; cycle();
    // same-cycle carry write must not feed bcy
    nop(); conditional = 3'd4; offset = 26'd3; carry_we = 1; carry_in = 1; cycle();
    chk("bcy_same_cycle", pc, 32'h40);
    // bl and br
    nop(); unconditional = 1; offset = 26'h10; cycle();
    chk("bl_target", pc, 32'h84);
    nop(); unconditional = 1; AdSel = 1; rs_value = 32'h103; cycle();
    chk("br_aligned", pc, 32'h100);
    // stall holds pc and carry
    nop(); stall = 1; carry_we = 1; carry_in = 0; unconditional = 1; offset = 26'd7;
    repeat (3) cycle();
    chk("stall_pc", pc, 32'h100);
    // wrap past all-ones
    nop(); unconditional = 1; AdSel = 1; rs_value = 32'hFFFF_FFFC; cycle();
    nop(); cycle();
    chk("wrap_pc", pc, 32'h0);
    // reset during stall
    nop(); stall = 1; reset = 1; carry_we = 1; carry_in = 1; cycle();
    chk("reset_in_stall", {31'b0, running}, 32'h0);
    // halt at 0x30 with branch fields set; start ignored
    nop(); start = 1; cycle();
    nop(); unconditional = 1; AdSel = 1; rs_value = 32'h30; cycle();
    nop(); halt = 1; unconditional = 1; offset = 26'd5; cycle();
    nop();
    for (int i = 0; i < 6; i++) begin
      start = i[0]; unconditional = 1; cycle();
    end
    chk("halt_hold", pc, 32'h30);
    nop(); reset = 1; cycle();
    chk("reset_after_halt", pc, 32'h0);
    // randomized cycles
    nop();
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 39) == 0);
      start         = ($urandom_range(0, 3) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      halt          = ($urandom_range(0, 29) == 0);
      unconditional = ($urandom_range(0, 5) == 0);
      conditional   = 3'($urandom_range(0, 7));
      AdSel         = ($urandom_range(0, 3) == 0);
      rs_value      = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      offset        = 26'($urandom);
      carry_we      = $urandom_range(0, 1) == 1;
      carry_in      = $urandom_range(0, 1) == 1;
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
